// File: rtl/hazard_flush_ctrl_pkg.sv
// Shared constants, types and FSM encoding for the pipeline hazard/flush controller.
package hazard_flush_ctrl_pkg;

  localparam int unsigned NREGS     = 32;
  localparam int unsigned REGNOBITS = 5;
  localparam int unsigned CNT_BITS  = 2;
  localparam int unsigned DBITS     = 32;

  typedef logic [REGNOBITS-1:0] regno_t;
  typedef logic [CNT_BITS-1:0]  cnt_t;
  typedef logic [DBITS-1:0]     word_t;

  // Saturation point of a per-register in-flight write counter.
  localparam cnt_t CntMax = {CNT_BITS{1'b1}};

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StFlush  = 2'd1,
    StRefill = 2'd2
  } state_e;

  // A read source hazards when it is used, not x0, and has writes in flight.
  // A lone in-flight write retiring this very cycle is forwarded by WB and does not hazard.
  function automatic logic src_hazard(logic use_src, regno_t idx, cnt_t cnt, logic bypass_hit);
    return use_src && (idx != '0) && (cnt != '0) && !(bypass_hit && (cnt == cnt_t'(1)));
  endfunction

endpackage

// File: rtl/hazard_flush_ctrl_if.sv
// Pipeline-side bundle of the hazard/flush controller: DE, WB and AGEX inputs plus controls.
interface hazard_flush_ctrl_if;
  import hazard_flush_ctrl_pkg::*;

  // DE stage
  logic   de_valid;
  regno_t de_rs1;
  regno_t de_rs2;
  logic   de_use_rs1;
  logic   de_use_rs2;
  logic   de_wr_en;
  regno_t de_rd;
  // WB stage
  logic   wb_valid;
  logic   wb_wr_en;
  regno_t wb_rd;
  // AGEX branch resolution
  logic   agex_redirect;
  word_t  agex_target;
  // Controls and status back to the pipeline
  logic   stall_de;
  logic   de_issue;
  logic   flush_fe;
  logic   flush_de;
  logic   fe_redirect_valid;
  word_t  fe_redirect_pc;
  word_t  stall_count;
  word_t  flush_count;
  logic   sb_error;

  // Pipeline side: drives stage information, consumes controls.
  modport master (
    output de_valid, de_rs1, de_rs2, de_use_rs1, de_use_rs2, de_wr_en, de_rd,
    output wb_valid, wb_wr_en, wb_rd, agex_redirect, agex_target,
    input  stall_de, de_issue, flush_fe, flush_de, fe_redirect_valid, fe_redirect_pc,
    input  stall_count, flush_count, sb_error
  );

  // Controller side.
  modport slave (
    input  de_valid, de_rs1, de_rs2, de_use_rs1, de_use_rs2, de_wr_en, de_rd,
    input  wb_valid, wb_wr_en, wb_rd, agex_redirect, agex_target,
    output stall_de, de_issue, flush_fe, flush_de, fe_redirect_valid, fe_redirect_pc,
    output stall_count, flush_count, sb_error
  );

endinterface

// File: rtl/hazard_flush_ctrl_reg_scoreboard.sv
// Per-register in-flight write counters with RAW lookup, WAW overflow and sticky underflow error.
module hazard_flush_ctrl_reg_scoreboard
  import hazard_flush_ctrl_pkg::*;
#(
  parameter bit WbBypass = 1'b1
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  // Issue of a register writer
  input  logic   inc_i,
  input  regno_t inc_idx_i,
  // Retire of a register writer
  input  logic   dec_i,
  input  regno_t dec_idx_i,
  // Source lookups
  input  logic   rs1_use_i,
  input  regno_t rs1_i,
  input  logic   rs2_use_i,
  input  regno_t rs2_i,
  // Destination lookup for overflow
  input  logic   wr_en_i,
  input  regno_t rd_i,
  output logic   rs1_hazard_o,
  output logic   rs2_hazard_o,
  output logic   overflow_o,
  output logic   error_o
);

  cnt_t cnt_q [NREGS];
  cnt_t cnt_d [NREGS];
  logic error_q, error_d;
  logic inc_eff, dec_eff;
  logic rs1_bypass, rs2_bypass;

  // Lookups use registered counts plus this cycle's WB retire for the bypass exception.
  always_comb begin
    rs1_bypass   = WbBypass && dec_i && (dec_idx_i == rs1_i);
    rs2_bypass   = WbBypass && dec_i && (dec_idx_i == rs2_i);
    rs1_hazard_o = src_hazard(rs1_use_i, rs1_i, cnt_q[rs1_i], rs1_bypass);
    rs2_hazard_o = src_hazard(rs2_use_i, rs2_i, cnt_q[rs2_i], rs2_bypass);
    overflow_o   = wr_en_i && (rd_i != '0) && (cnt_q[rd_i] == CntMax);
    error_o      = error_q;
  end

  // Next counts: x0 is never tracked; a matched issue/retire pair cancels out.
  always_comb begin
    cnt_d   = cnt_q;
    error_d = error_q;
    inc_eff = inc_i && (inc_idx_i != '0);
    dec_eff = dec_i && (dec_idx_i != '0);
    if (!(inc_eff && dec_eff && (inc_idx_i == dec_idx_i))) begin
      if (inc_eff) begin
        cnt_d[inc_idx_i] = cnt_q[inc_idx_i] + cnt_t'(1);
      end
      if (dec_eff) begin
        if (cnt_q[dec_idx_i] == '0) begin
          error_d = 1'b1;
        end else begin
          cnt_d[dec_idx_i] = cnt_q[dec_idx_i] - cnt_t'(1);
        end
      end
    end
  end

  // Counter array and sticky error state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREGS; i++) begin
        cnt_q[i] <= '0;
      end
      error_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      error_q <= error_d;
    end
  end

endmodule

// File: rtl/hazard_flush_ctrl.sv
// Pipeline control: RAW/WAW issue gating, branch-redirect flush sequencing and perf counters.
module hazard_flush_ctrl
  import hazard_flush_ctrl_pkg::*;
#(
  parameter int unsigned RefillCycles = 1,
  parameter bit          WbBypass     = 1'b1
) (
  input logic                clk,
  input logic                reset_n,
  hazard_flush_ctrl_if.slave pipe
);

  localparam logic [1:0] RefillLoad = 2'(RefillCycles);

  state_e     state_q;
  logic       flush_q;
  logic [1:0] refill_q;
  word_t      redirect_pc_q;
  word_t      stall_count_q;
  word_t      flush_count_q;

  logic rs1_hazard, rs2_hazard, overflow, sb_error;
  logic de_issue, stall_de, sb_inc, sb_dec;

  hazard_flush_ctrl_reg_scoreboard #(
    .WbBypass(WbBypass)
  ) u_scoreboard (
    .clk_i       (clk),
    .rst_ni      (reset_n),
    .inc_i       (sb_inc),
    .inc_idx_i   (pipe.de_rd),
    .dec_i       (sb_dec),
    .dec_idx_i   (pipe.wb_rd),
    .rs1_use_i   (pipe.de_use_rs1),
    .rs1_i       (pipe.de_rs1),
    .rs2_use_i   (pipe.de_use_rs2),
    .rs2_i       (pipe.de_rs2),
    .wr_en_i     (pipe.de_wr_en),
    .rd_i        (pipe.de_rd),
    .rs1_hazard_o(rs1_hazard),
    .rs2_hazard_o(rs2_hazard),
    .overflow_o  (overflow),
    .error_o     (sb_error)
  );

  // Issue decision; a redirect cycle blocks issue since DE holds a wrong-path instruction.
  // Reset is folded in so the controls read 0 while reset is held.
  always_comb begin
    de_issue = reset_n && pipe.de_valid && (state_q == StRun) && !rs1_hazard && !rs2_hazard &&
               !overflow && !pipe.agex_redirect;
    stall_de = reset_n && pipe.de_valid && !de_issue && !flush_q;
    sb_inc   = de_issue && pipe.de_wr_en;
    sb_dec   = pipe.wb_valid && pipe.wb_wr_en;
  end

  // Redirect FSM with registered flush strobe, refill down-counter and target register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StRun;
      flush_q       <= 1'b0;
      refill_q      <= '0;
      redirect_pc_q <= '0;
    end else if (pipe.agex_redirect) begin
      // A redirect in any state is the youngest one: it restarts the whole sequence.
      state_q       <= StFlush;
      flush_q       <= 1'b1;
      refill_q      <= '0;
      redirect_pc_q <= pipe.agex_target;
    end else begin
      unique case (state_q)
        StRun: begin
          flush_q <= 1'b0;
        end
        StFlush: begin
          flush_q <= 1'b0;
          if (RefillCycles > 0) begin
            state_q  <= StRefill;
            refill_q <= RefillLoad;
          end else begin
            state_q <= StRun;
          end
        end
        StRefill: begin
          if (refill_q <= 2'd1) begin
            state_q  <= StRun;
            refill_q <= '0;
          end else begin
            refill_q <= refill_q - 2'd1;
          end
        end
        default: begin
          state_q  <= StRun;
          flush_q  <= 1'b0;
          refill_q <= '0;
        end
      endcase
    end
  end

  // Performance counters, wrapping naturally at the word width.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      if (stall_de) begin
        stall_count_q <= stall_count_q + word_t'(1);
      end
      if (flush_q) begin
        flush_count_q <= flush_count_q + word_t'(1);
      end
    end
  end

  assign pipe.de_issue          = de_issue;
  assign pipe.stall_de          = stall_de;
  assign pipe.flush_fe          = flush_q;
  assign pipe.flush_de          = flush_q;
  assign pipe.fe_redirect_valid = flush_q;
  assign pipe.fe_redirect_pc    = redirect_pc_q;
  assign pipe.stall_count       = stall_count_q;
  assign pipe.flush_count       = flush_count_q;
  assign pipe.sb_error          = sb_error;

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Randomised and directed bench for hazard_flush_ctrl against a behavioural pipeline model.
module tb_hazard_flush_ctrl;
  import hazard_flush_ctrl_pkg::*;

  localparam int unsigned RefillCycles = 1;
  localparam bit          WbBypass     = 1'b1;
  localparam int          MaxCnt       = (1 << CNT_BITS) - 1;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  hazard_flush_ctrl_if bus ();

  hazard_flush_ctrl #(
    .RefillCycles(RefillCycles),
    .WbBypass    (WbBypass)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .pipe   (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: writes in flight per register, error flag, redirect window length, counters.
  int          m_cnt [NREGS];
  bit          m_err;
  logic [31:0] m_pc, m_stall, m_flush;
  int          m_busy;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int r = 0; r < NREGS; r++) m_cnt[r] = 0;
    m_err = 0; m_pc = '0; m_stall = '0; m_flush = '0; m_busy = 0;
  endfunction

  function automatic bit model_hazard(bit u, int r, bit wb_wr, int wrd);
    if (!u || r == 0 || m_cnt[r] == 0) return 1'b0;
    if (WbBypass && m_cnt[r] == 1 && wb_wr && wrd == r) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check_outputs(input bit issue, input bit stall, input bit flush);
    check_eq("de_issue", {31'b0, bus.de_issue}, {31'b0, issue});
    check_eq("stall_de", {31'b0, bus.stall_de}, {31'b0, stall});
    check_eq("flush_fe", {31'b0, bus.flush_fe}, {31'b0, flush});
    check_eq("flush_de", {31'b0, bus.flush_de}, {31'b0, flush});
    check_eq("fe_redirect_valid", {31'b0, bus.fe_redirect_valid}, {31'b0, flush});
    check_eq("fe_redirect_pc", bus.fe_redirect_pc, m_pc);
    check_eq("stall_count", bus.stall_count, m_stall);
    check_eq("flush_count", bus.flush_count, m_flush);
    check_eq("sb_error", {31'b0, bus.sb_error}, {31'b0, m_err});
  endtask

  // One pipeline cycle: drive at negedge, check, then advance the model at posedge.
  task automatic apply(input bit dv, input int r1, input bit u1, input int r2, input bit u2,
                       input bit wr, input int rd, input bit wbv, input bit wbw, input int wrd,
                       input bit redir, input logic [31:0] tgt);
    bit run, flush, h1, h2, ovf, issue, stall, inc, dec;
    @(negedge clk);
    bus.de_valid = dv; bus.de_rs1 = regno_t'(r1); bus.de_use_rs1 = u1;
    bus.de_rs2 = regno_t'(r2); bus.de_use_rs2 = u2; bus.de_wr_en = wr; bus.de_rd = regno_t'(rd);
    bus.wb_valid = wbv; bus.wb_wr_en = wbw; bus.wb_rd = regno_t'(wrd);
    bus.agex_redirect = redir; bus.agex_target = tgt;
    #1;
    run   = (m_busy == 0);
    flush = (m_busy == 1 + int'(RefillCycles));
    h1    = model_hazard(u1, r1, wbv && wbw, wrd);
    h2    = model_hazard(u2, r2, wbv && wbw, wrd);
    ovf   = wr && rd != 0 && m_cnt[rd] == MaxCnt;
    issue = dv && run && !h1 && !h2 && !ovf && !redir;
    stall = dv && !issue && !flush;
    check_outputs(issue, stall, flush);
    @(posedge clk);
    inc = issue && wr && rd != 0;
    dec = wbv && wbw && wrd != 0;
    if (!(inc && dec && rd == wrd)) begin
      if (inc) m_cnt[rd]++;
      if (dec) begin
        if (m_cnt[wrd] == 0) m_err = 1'b1;
        else m_cnt[wrd]--;
      end
    end
    if (stall) m_stall++;
    if (flush) m_flush++;
    if (redir) begin
      m_pc   = tgt;
      m_busy = 1 + int'(RefillCycles);
    end else if (m_busy > 0) begin
      m_busy--;
    end
  endtask

  task automatic idle();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
  endtask

  // Asynchronous reset asserted mid-cycle: controls must drop at once.
  task automatic reset_mid_cycle();
    @(negedge clk);
    bus.de_valid = 1; bus.de_rs1 = regno_t'(5); bus.de_use_rs1 = 1;
    bus.de_wr_en = 0; bus.wb_valid = 0; bus.wb_wr_en = 0; bus.agex_redirect = 0;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs(0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic random_phase(input int cycles);
    int q[$];
    int wrd;
    for (int i = 0; i < cycles; i++) begin
      q.delete();
      for (int r = 1; r < 8; r++) if (m_cnt[r] != 0) q.push_back(r);
      if (q.size() > 0 && $urandom_range(0, 9) < 9) wrd = q[$urandom_range(0, q.size() - 1)];
      else wrd = int'($urandom_range(0, 7));
      apply($urandom_range(0, 9) < 7, int'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
            int'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
            $urandom_range(0, 9) < 6, int'($urandom_range(0, 7)),
            $urandom_range(0, 99) < 45, $urandom_range(0, 9) < 8, wrd,
            $urandom_range(0, 99) < 7, $urandom());
    end
  endtask

  initial begin
    reset_n = 1'b0;
    bus.de_valid = 0; bus.de_rs1 = '0; bus.de_rs2 = '0; bus.de_use_rs1 = 0; bus.de_use_rs2 = 0;
    bus.de_wr_en = 0; bus.de_rd = '0; bus.wb_valid = 0; bus.wb_wr_en = 0; bus.wb_rd = '0;
    bus.agex_redirect = 0; bus.agex_target = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_outputs(0, 0, 0);
    reset_n = 1'b1;

    // RAW on x5: two stalls, then issue in the retire cycle via WB bypass.
    apply(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 32'h0);
    apply(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    apply(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    apply(1, 5, 1, 0, 0, 0, 0, 1, 1, 5, 0, 32'h0);
    check_eq("tp_raw_stall_count", bus.stall_count, 32'd2);

    // WAW overflow on x7: fourth writer waits for one retire, issues the cycle after.
    repeat (3) apply(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 32'h0);
    apply(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 32'h0);
    apply(1, 0, 0, 0, 0, 1, 7, 1, 1, 7, 0, 32'h0);
    apply(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 32'h0);
    repeat (3) apply(0, 0, 0, 0, 0, 0, 0, 1, 1, 7, 0, 32'h0);

    // Redirect to 0x100 (wrong-path DE blocked), then a younger redirect during REFILL.
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0100);
    idle();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0200);
    idle();
    idle();
    idle();
    check_eq("tp_flush_count", bus.flush_count, 32'd2);
    check_eq("tp_redirect_pc", bus.fe_redirect_pc, 32'h0000_0200);

    // Same-cycle issue and retire of x9 leaves its count at 1.
    apply(1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 32'h0);
    apply(1, 0, 0, 0, 0, 1, 9, 1, 1, 9, 0, 32'h0);
    apply(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    apply(0, 0, 0, 0, 0, 0, 0, 1, 1, 9, 0, 32'h0);

    random_phase(800);

    // Reset during REFILL with x5 busy; the first read of x5 afterwards must issue.
    apply(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 32'h0);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0300);
    idle();
    reset_mid_cycle();
    apply(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);

    // Retire of x3 at zero count sets a sticky error.
    apply(0, 0, 0, 0, 0, 0, 0, 1, 1, 3, 0, 32'h0);
    idle();
    idle();
    check_eq("tp_sb_error_sticky", {31'b0, bus.sb_error}, 32'd1);

    random_phase(800);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_flush_ctrl.md
Name: hazard_flush_ctrl

Overview:
- Pipeline control block for the five-stage core (FE, DE, AGEX, MEM, WB).
- Tracks in-flight register writes in a per-register scoreboard and stalls DE on RAW hazards.
- Sequences the front-end flush and PC redirect when AGEX resolves a taken branch or jump.
- Keeps stall and flush performance counters.

Parameters:
- NREGS, 32, number of architectural registers (x0 is never tracked).
- REGNOBITS, 5, register index width, log2(NREGS).
- CNT_BITS, 2, per-register in-flight write counter width; max count is 2^CNT_BITS-1.
- DBITS, 32, PC and counter width.
- REFILL_CYCLES, 1, issue-blocked cycles after a flush (0..3).
- WB_BYPASS, 1, if 1 a same-cycle WB retire to the source register resolves a count==1 hazard.

Ports:
- clk, in, 1, clock.
- reset_n, in, 1, asynchronous active-low reset.
- de_valid, in, 1, DE holds a valid instruction.
- de_rs1 / de_rs2, in, REGNOBITS each, source registers.
- de_use_rs1 / de_use_rs2, in, 1 each, the source is actually read.
- de_wr_en, in, 1, DE instruction writes rd.
- de_rd, in, REGNOBITS, destination register.
- wb_valid, in, 1, WB retiring a valid instruction.
- wb_wr_en, in, 1, the retiring instruction writes a register.
- wb_rd, in, REGNOBITS, retiring destination.
- agex_redirect, in, 1, AGEX resolved a taken branch or jump this cycle.
- agex_target, in, DBITS, redirect PC.
- stall_de, out, 1, hold the FE and DE latches; DE issues a bubble.
- de_issue, out, 1, DE instruction advances into AGEX this cycle.
- flush_fe / flush_de, out, 1 each, squash the FE and DE latch contents.
- fe_redirect_valid, out, 1, FE loads fe_redirect_pc.
- fe_redirect_pc, out, DBITS, registered target.
- stall_count / flush_count, out, DBITS each, performance counters.
- sb_error, out, 1, sticky error: retire seen with a zero count.

Behaviour:
- Reset (asynchronous, any cycle, including mid-flush):
  - All scoreboard counters, both perf counters, fe_redirect_pc and sb_error go to 0.
  - FSM goes to RUN.
  - All control outputs are 0.
- Hazard (combinational from registered state and this cycle's inputs): a source hazards when its use bit is set, its index is nonzero and cnt[rs] != 0.
  - Exception: when WB_BYPASS=1, a source with cnt[rs]==1 and wb_valid & wb_wr_en & wb_rd==rs does not hazard.
- Issue blocking: issue is also blocked when de_wr_en, de_rd != 0 and cnt[de_rd] is at max (WAW overflow).
- de_issue = de_valid & state==RUN & !hazard & !overflow & !agex_redirect.
- stall_de = de_valid & !de_issue & !flush_de.
- Scoreboard update, each cycle:
  - cnt[de_rd] +1 when de_issue & de_wr_en & de_rd != 0.
  - cnt[wb_rd] -1 when wb_valid & wb_wr_en & wb_rd != 0.
  - Same register, both events in one cycle: the count is unchanged.
  - A decrement of a zero count is dropped and sets sb_error, which holds until reset.
- FSM states RUN, FLUSH, REFILL:
  - RUN -> FLUSH on agex_redirect; fe_redirect_pc <= agex_target.
  - FLUSH, exactly 1 cycle: flush_fe = flush_de = fe_redirect_valid = 1. Go to REFILL if REFILL_CYCLES > 0, otherwise RUN.
  - REFILL: a down-counter loaded with REFILL_CYCLES; de_issue = 0; go to RUN when the counter reaches 1.
  - agex_redirect in FLUSH or REFILL is a newer, younger redirect: reload the target, re-enter FLUSH and restart REFILL.
- Flushed instructions were never issued, so flushes cause no scoreboard rollback.
- A redirect cycle in RUN blocks de_issue, because the DE instruction is wrong-path.
- Counters: stall_count +1 per cycle with stall_de=1; flush_count +1 per FLUSH cycle. Both wrap modulo 2^DBITS.
- Latency: hazard to stall is 0 cycles; redirect to fe_redirect_valid is 1 cycle.

Decomposition:
- Shared define header holds the constants: REGNOBITS, DBITS, the FSM state encodings and CNT_BITS.
- One sub-module, reg_scoreboard: counter array, inc/dec ports, two hazard lookup ports, overflow flag and error flag.
- The FSM, the redirect register and the perf counters stay in the top level.

Test Plan:
- Issue x5 write, then next cycle DE reads rs1=x5 -> stall_de=1 until WB retires x5. With WB_BYPASS=1, stall drops in the retire cycle and de_issue=1 in that same cycle. stall_count equals the number of stalled cycles.
- Issue three writes to x7 with no retire -> cnt[x7]=3; a fourth writer stalls (overflow). One WB retire of x7 -> the fourth writer issues in the next cycle.
- agex_redirect=1 with agex_target=0x0000_0100 -> next cycle flush_fe=flush_de=fe_redirect_valid=1 and fe_redirect_pc=0x100. With REFILL_CYCLES=1, one cycle with de_issue=0, then RUN. flush_count=1.
- Redirect to 0x200 during REFILL -> FLUSH re-entered, fe_redirect_pc=0x200, flush_count=2.
- Same-cycle issue and retire of x9 at cnt=1 -> cnt stays 1. WB retire of x3 at cnt=0 -> sb_error=1 and stays set.
- Assert reset_n=0 mid-REFILL with nonzero counts -> immediately all outputs 0, state RUN, counts 0; the first DE read of a previously busy register issues without stall.
